// File: rtl/regfile_pkg.sv
// regfile_pkg: definitions shared by the register file and decode.
//   rf_state_e  : clear-sweep FSM states
//   RF_WIDTH    : default register width
//   RF_DEPTH    : default number of registers
package regfile_pkg;

    localparam int RF_WIDTH = 32;
    localparam int RF_DEPTH = 32;

    typedef enum logic {
        RF_SWEEP = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_e;

endpackage

// File: rtl/regfile_sweep.sv
// regfile_sweep: clear-sweep controller for the register file.
// After reset, or on an accepted clear request, it walks a counter
// 0..DEPTH-1 and writes zero to one entry per clock edge. The storage
// array can therefore live in RAM without a reset.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset
//   clr_req  in   clear request, honoured only while not sweeping
//   busy     out  high while the sweep runs
//   clr_we   out  zero-write enable for the storage array
//   clr_addr out  entry being cleared on the next edge
module regfile_sweep
    import regfile_pkg::*;
#(
    parameter int DEPTH = RF_DEPTH,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_req,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    rf_state_e     state;
    logic [AW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RF_SWEEP;
            cnt   <= '0;
            busy  <= 1'b1;
        end else begin
            case (state)
                RF_SWEEP: begin
                    if (cnt == LAST) begin
                        state <= RF_RUN;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RF_RUN: begin
                    if (clr_req) begin
                        state <= RF_SWEEP;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= RF_SWEEP;
                    busy  <= 1'b1;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // busy is a flop that tracks state == RF_SWEEP, so the zero-write
    // enable comes straight from a register.
    assign clr_we   = busy;
    assign clr_addr = cnt;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port general-purpose register file.
// NREAD combinational read ports, two prioritised write ports (port 1
// wins), optional hard-wired zero register, optional same-cycle
// write-to-read bypass, and a per-register pending bit for issue hazards.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   rd_addr   in   NREAD read addresses, port i at [i*AW +: AW]
//   rd_data   out  NREAD read data words, port i at [i*WIDTH +: WIDTH]
//   rd_pend   out  pending flag of each read address
//   wr_en     in   write enables, ports 0 and 1
//   wr_addr   in   write addresses, port p at [p*AW +: AW]
//   wr_data   in   write data, port p at [p*WIDTH +: WIDTH]
//   pend_set  in   mark pend_addr pending
//   pend_addr in   target of pend_set
//   clr_req   in   start a clear sweep (ignored while busy)
//   busy      out  clear sweep in progress
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH,
    parameter int DEPTH    = RF_DEPTH,
    parameter int NREAD    = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1,
    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREAD*AW-1:0]    rd_addr,
    output logic [NREAD*WIDTH-1:0] rd_data,
    output logic [NREAD-1:0]       rd_pend,
    input  logic [1:0]             wr_en,
    input  logic [2*AW-1:0]        wr_addr,
    input  logic [2*WIDTH-1:0]     wr_data,
    input  logic                   pend_set,
    input  logic [AW-1:0]          pend_addr,
    input  logic                   clr_req,
    output logic                   busy
);

    // An address is usable if it names a real entry and is not the
    // hard-wired zero register. The compare is widened by one bit so it
    // stays meaningful when DEPTH is a power of two.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        logic ok;
        ok = ({1'b0, a} < (AW+1)'(DEPTH));
        if (ZERO_REG && (a == '0)) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

    logic          clr_we;
    logic [AW-1:0] clr_addr;

    regfile_sweep #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_sweep (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // Write-port decode. we_eff marks writes that will really happen on
    // the next edge; bypass and pending-clear both key off it so that a
    // dropped write never leaks into a read.
    logic [AW-1:0]    wa [2];
    logic [WIDTH-1:0] wd [2];
    logic [1:0]       we_eff;
    logic             ps_eff;
    logic             clr_go;

    always_comb begin
        // NOTE: every always_comb output gets a default first; a path that
        // leaves one unassigned would infer a latch.
        we_eff = '0;
        for (int p = 0; p < 2; p++) begin
            wa[p]     = wr_addr[p*AW +: AW];
            wd[p]     = wr_data[p*WIDTH +: WIDTH];
            we_eff[p] = !busy && wr_en[p] && addr_ok(wa[p]);
        end
        ps_eff = !busy && pend_set && addr_ok(pend_addr);
        clr_go = !busy && clr_req;
    end

    // Storage array. Port 1 is written last so it wins on an address
    // collision; during a sweep only the zero write is active.
    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset on purpose so it can map to RAM; the
    // sweep clears it after reset instead.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else begin
            if (we_eff[0]) begin
                mem[wa[0]] <= wd[0];
            end
            if (we_eff[1]) begin
                mem[wa[1]] <= wd[1];
            end
        end
    end

    // Pending bitmap. A write clears its bit; pend_set is applied last so
    // a same-cycle set on the same register wins over the clear.
    logic [DEPTH-1:0] pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= '0;
        end else if (clr_go) begin
            pend <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (we_eff[p]) begin
                    pend[wa[p]] <= 1'b0;
                end
            end
            if (ps_eff) begin
                pend[pend_addr] <= 1'b1;
            end
        end
    end

    // Read ports: forced to zero while busy or for unusable addresses,
    // otherwise the stored value with optional forwarding (port 1 first).
    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [AW-1:0]    ra;
        logic [WIDTH-1:0] d;
        logic             p;

        always_comb begin
            ra = rd_addr[i*AW +: AW];
            d  = '0;
            p  = 1'b0;
            if (!busy && addr_ok(ra)) begin
                d = mem[ra];
                p = pend[ra];
                if (BYPASS) begin
                    if (we_eff[1] && (wa[1] == ra)) begin
                        d = wd[1];
                        p = 1'b0;
                    end else if (we_eff[0] && (wa[0] == ra)) begin
                        d = wd[0];
                        p = 1'b0;
                    end
                end
            end
        end

        assign rd_data[i*WIDTH +: WIDTH] = d;
        assign rd_pend[i]                = p;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed bench for regfile_mp. Two instances share the
// write/pending/clear inputs: dut_a (DEPTH=32, NREAD=2) and dut_b
// (DEPTH=24, NREAD=3) for the non-power-of-two address checks.
module tb_regfile_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        pend_set;
    logic [4:0]  pend_addr;
    logic        clr_req;

    logic [9:0]  a_rd_addr;
    logic [63:0] a_rd_data;
    logic [1:0]  a_rd_pend;
    logic        a_busy;

    logic [14:0] b_rd_addr;
    logic [95:0] b_rd_data;
    logic [2:0]  b_rd_pend;
    logic        b_busy;

    int n_cmp  = 0;
    int n_fail = 0;
    int ea;
    int eb;
    int bad;

    regfile_mp #(
        .WIDTH(32), .DEPTH(32), .NREAD(2), .ZERO_REG(1'b1), .BYPASS(1'b1)
    ) dut_a (
        .clk(clk), .rst(rst),
        .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_pend(a_rd_pend),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pend_set(pend_set), .pend_addr(pend_addr),
        .clr_req(clr_req), .busy(a_busy)
    );

    regfile_mp #(
        .WIDTH(32), .DEPTH(24), .NREAD(3), .ZERO_REG(1'b1), .BYPASS(1'b1)
    ) dut_b (
        .clk(clk), .rst(rst),
        .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_pend(b_rd_pend),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pend_set(pend_set), .pend_addr(pend_addr),
        .clr_req(clr_req), .busy(b_busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en    = 2'b00;
        pend_set = 1'b0;
        clr_req  = 1'b0;
    endtask

    task automatic set_write(input int p, input logic [4:0] addr, input logic [31:0] data);
        wr_en[p]           = 1'b1;
        wr_addr[p*5 +: 5]  = addr;
        wr_data[p*32 +: 32] = data;
    endtask

    initial begin
        // ---------------- reset ----------------
        rst       = 1'b1;
        idle();
        wr_addr   = '0;
        wr_data   = '0;
        pend_addr = '0;
        a_rd_addr = {5'd7, 5'd5};
        b_rd_addr = '0;
        #2;
        check("rst_busy_a", a_busy, 1);
        check("rst_busy_b", b_busy, 1);
        check("rst_rd_data", a_rd_data, 0);
        check("rst_rd_pend", a_rd_pend, 0);
        repeat (3) tick();
        rst = 1'b0;

        // Count edges after release until each instance drops busy.
        ea = 0;
        eb = 0;
        for (int n = 1; n <= 60; n++) begin
            tick();
            if (!a_busy && ea == 0) ea = n;
            if (!b_busy && eb == 0) eb = n;
            if (ea != 0 && eb != 0) break;
        end
        check("sweep_len_a", ea, 32);
        check("sweep_len_b", eb, 24);

        bad = 0;
        for (int a = 0; a < 32; a++) begin
            a_rd_addr = {5'(a), 5'(a)};
            #1;
            if (a_rd_data !== 64'd0 || a_rd_pend !== 2'b00) bad++;
        end
        check("post_sweep_zero", bad, 0);
        tick();

        // ---------------- writes ----------------
        set_write(0, 5'd5, 32'hA5A5_A5A5);
        a_rd_addr = {5'd0, 5'd5};
        #1;
        check("bypass_r5", a_rd_data[31:0], 32'hA5A5_A5A5);
        tick();
        idle();
        #1;
        check("stored_r5", a_rd_data[31:0], 32'hA5A5_A5A5);

        set_write(0, 5'd7, 32'h1);
        set_write(1, 5'd7, 32'h2);
        a_rd_addr = {5'd7, 5'd7};
        #1;
        check("bypass_r7_p1_wins", a_rd_data[63:32], 32'h2);
        tick();
        idle();
        #1;
        check("stored_r7_p1_wins", a_rd_data[31:0], 32'h2);

        set_write(0, 5'd0, 32'hFFFF);
        a_rd_addr = {5'd0, 5'd0};
        #1;
        check("r0_no_bypass", a_rd_data[31:0], 0);
        tick();
        idle();
        #1;
        check("r0_reads_zero", a_rd_data[31:0], 0);

        // ---------------- pending bits ----------------
        pend_set  = 1'b1;
        pend_addr = 5'd3;
        a_rd_addr = {5'd0, 5'd3};
        #1;
        check("pend_not_yet", a_rd_pend[0], 0);
        tick();
        pend_set = 1'b0;
        #1;
        check("pend_set_r3", a_rd_pend[0], 1);
        set_write(1, 5'd3, 32'h33);
        #1;
        check("pend_bypass_clear", a_rd_pend[0], 0);
        tick();
        idle();
        #1;
        check("pend_write_clear", a_rd_pend[0], 0);
        pend_set  = 1'b1;
        pend_addr = 5'd3;
        set_write(0, 5'd3, 32'h44);
        tick();
        idle();
        #1;
        check("pend_set_wins", a_rd_pend[0], 1);
        check("r3_data", a_rd_data[31:0], 32'h44);

        // ---------------- clear request ----------------
        set_write(0, 5'd9, 32'h1234);
        pend_set  = 1'b1;
        pend_addr = 5'd12;
        tick();
        idle();
        a_rd_addr = {5'd12, 5'd9};
        #1;
        check("r9_before_clr", a_rd_data[31:0], 32'h1234);
        check("pend_r12", a_rd_pend[1], 1);

        clr_req = 1'b1;
        tick();
        clr_req   = 1'b0;
        a_rd_addr = {5'd9, 5'd7};
        #1;
        check("clr_busy", a_busy, 1);
        check("busy_forces_zero", a_rd_data[31:0], 0);

        ea = 0;
        for (int n = 1; n <= 60; n++) begin
            tick();
            if (!a_busy) begin
                ea = n;
                break;
            end
            if (n == 5) begin
                set_write(0, 5'd9, 32'hDEAD);
                pend_set  = 1'b1;
                pend_addr = 5'd9;
                #1;
                check("busy_no_bypass", a_rd_data[63:32], 0);
                check("busy_pend_forced", a_rd_pend[1], 0);
            end
            if (n == 6) idle();
            if (n == 10) clr_req = 1'b1;
            if (n == 11) clr_req = 1'b0;
        end
        check("clr_sweep_len", ea, 32);
        a_rd_addr = {5'd12, 5'd9};
        #1;
        check("r9_cleared", a_rd_data[31:0], 0);
        check("r9_pend_ignored", a_rd_pend[0], 0);
        check("r12_pend_cleared", a_rd_pend[1], 0);

        // ---------------- DEPTH=24 boundaries ----------------
        tick();
        set_write(0, 5'd30, 32'hBEEF);
        set_write(1, 5'd23, 32'h77);
        pend_set  = 1'b1;
        pend_addr = 5'd30;
        b_rd_addr = {5'd30, 5'd0, 5'd23};
        #1;
        check("b_oor_no_bypass", b_rd_data[95:64], 0);
        check("b_r23_bypass", b_rd_data[31:0], 32'h77);
        tick();
        idle();
        #1;
        check("b_oor_read", b_rd_data[95:64], 0);
        check("b_oor_pend", b_rd_pend[2], 0);
        check("b_r23_stored", b_rd_data[31:0], 32'h77);

        // rst pulsed at cnt==10 of a clear sweep restarts a full sweep.
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        #1;
        check("b_rst_busy", b_busy, 1);
        #1;
        rst = 1'b0;
        eb = 0;
        for (int n = 1; n <= 60; n++) begin
            tick();
            if (!b_busy) begin
                eb = n;
                break;
            end
        end
        check("b_restart_len", eb, 24);
        check("a_still_busy", a_busy, 1);
        #1;
        check("b_r23_cleared", b_rd_data[31:0], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
